// File: rtl/speed_seq_pkg.sv
// Shared types and constants for the speed-ramp controller.
package speed_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEL  = 3'd1,
    ST_CRUISE = 3'd2,
    ST_DECEL  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SPD_FAST = 2'b00;
  localparam logic [1:0] SPD_SLOW = 2'b11;

endpackage

// File: rtl/speed_sequencer_btn_pulse_sync.sv
// Button conditioner: 2-flop synchronizer plus rising-edge detector.
// Only compiled in when SPEED_SEQ_BTN_SYNC_EN is defined.
`ifdef SPEED_SEQ_BTN_SYNC_EN
module btn_pulse_sync (
  input  logic ClockIn,
  input  logic Reset,
  input  logic raw,
  output logic pulse
);

  logic meta, sync, sync_d;

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= raw;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // One pulse per press, however long the button is held.
  assign pulse = sync & ~sync_d;

endmodule
`endif

// File: rtl/speed_sequencer.sv
// Speed-ramp controller for the rate-divider / display-counter pair.
// Optional button conditioning on Go/Halt: SPEED_SEQ_BTN_SYNC_EN.
module speed_sequencer
  import speed_seq_pkg::*;
#(
  parameter int DWELL_TICKS = 4
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Go,
  input  logic       Halt,
  input  logic       Tick,
  input  logic [3:0] Target,
  input  logic [3:0] CounterValue,
  output logic [1:0] Speed,
  output logic       RunEn,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] StateOut
);

  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  logic go_cmd, halt_cmd;

`ifdef SPEED_SEQ_BTN_SYNC_EN
  btn_pulse_sync u_go_sync (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .raw     (Go),
    .pulse   (go_cmd)
  );
  btn_pulse_sync u_halt_sync (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .raw     (Halt),
    .pulse   (halt_cmd)
  );
`else
  assign go_cmd   = Go;
  assign halt_cmd = Halt;
`endif

  state_t          state, state_nx;
  logic [1:0]      speed_nx;
  logic [DW-1:0]   dwell, dwell_nx;
  logic            armed, armed_nx;
  logic            run_nx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    speed_nx = Speed;
    dwell_nx = dwell;
    run_nx   = RunEn;
    armed_nx = armed;

    if (Tick && (state == ST_ACCEL || state == ST_CRUISE || state == ST_DECEL))
      armed_nx = 1'b1;

    case (state)
      ST_IDLE: begin
        if (go_cmd && !halt_cmd) begin
          state_nx = ST_ACCEL;
          speed_nx = SPD_SLOW;
          run_nx   = 1'b1;
          dwell_nx = '0;
          armed_nx = 1'b0;
        end
      end
      ST_ACCEL, ST_CRUISE: begin
        // Stop requests take priority over a dwell step on the same edge.
        if (halt_cmd || (armed && CounterValue == Target)) begin
          state_nx = ST_DECEL;
          dwell_nx = '0;
        end else if (state == ST_ACCEL && Tick) begin
          if (dwell == DWELL_LAST) begin
            dwell_nx = '0;
            if (Speed != SPD_FAST) speed_nx = Speed - 2'd1;
            if (Speed == 2'b01 || Speed == SPD_FAST) state_nx = ST_CRUISE;
          end else begin
            dwell_nx = dwell + DWELL_ONE;
          end
        end
      end
      ST_DECEL: begin
        if (Tick) begin
          if (dwell == DWELL_LAST) begin
            dwell_nx = '0;
            if (Speed != SPD_SLOW) begin
              speed_nx = Speed + 2'd1;
            end else begin
              state_nx = ST_DONE;
              run_nx   = 1'b0;
            end
          end else begin
            dwell_nx = dwell + DWELL_ONE;
          end
        end
      end
      ST_DONE: begin
        if (halt_cmd) begin
          state_nx = ST_IDLE;
        end else if (go_cmd) begin
          state_nx = ST_ACCEL;
          speed_nx = SPD_SLOW;
          run_nx   = 1'b1;
          dwell_nx = '0;
          armed_nx = 1'b0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        speed_nx = SPD_SLOW;
        run_nx   = 1'b0;
        dwell_nx = '0;
        armed_nx = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      Speed    <= SPD_SLOW;
      RunEn    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      StateOut <= 3'd0;
      dwell    <= '0;
      armed    <= 1'b0;
    end else begin
      state    <= state_nx;
      Speed    <= speed_nx;
      RunEn    <= run_nx;
      Busy     <= (state_nx == ST_ACCEL) || (state_nx == ST_CRUISE) || (state_nx == ST_DECEL);
      Done     <= (state_nx == ST_DONE);
      StateOut <= state_nx;
      dwell    <= dwell_nx;
      armed    <= armed_nx;
    end
  end

endmodule

// File: doc/speed_sequencer.md
# speed_sequencer

Speed-ramp controller for the rate-divider / display-counter datapath. The block drives the divider's 2-bit Speed select and gates the counter's advance. On a start command it ramps from slowest to fastest speed, cruises, and ramps back down when the counter reaches a programmed target or a halt is commanded. It sits between the board push-buttons and the divider/counter pair, and watches the divider's Enable tick and the live counter value.

## Interface
- DWELL_TICKS, default 4: Tick pulses spent at each speed step during a ramp. Legal range is ≥1.
- ClockIn  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Go  in  1  start command, single-cycle pulse.
- Halt  in  1  stop command, single-cycle pulse.
- Tick  in  1  divider Enable, single-cycle pulse.
- Target  in  4  counter value that triggers deceleration.
- CounterValue  in  4  live display-counter value.
- Speed  out  2  divider speed select. 2'b00 is fastest, 2'b11 is slowest.
- RunEn  out  1  gates the counter's EnableDC (counter EnableDC = Tick & RunEn).
- Busy  out  1  high in ACCEL, CRUISE and DECEL.
- Done  out  1  high in DONE.
- StateOut  out  3  current state encoding, for debug LEDs.

## Operation
- States and encodings: IDLE=0, ACCEL=1, CRUISE=2, DECEL=3, DONE=4.
- All outputs are registered.
- Dwell counter: width $clog2(DWELL_TICKS+1). It increments only on Tick while Busy, and clears on every speed step and on every state change.
- **IDLE**
  - Speed=11, RunEn=0.
  - Go → ACCEL, with Speed=11, RunEn=1, dwell=0, armed=0.
- **ACCEL**
  - On a Tick with dwell==DWELL_TICKS-1: Speed decrements by 1 and dwell clears.
  - If the new Speed is 00, the state moves to CRUISE on the same edge.
- **CRUISE**
  - Speed holds at 00.
- **Deceleration triggers**, evaluated every cycle in ACCEL or CRUISE: Halt, or (armed & CounterValue==Target). Either one moves the state to DECEL at the current Speed, with dwell=0.
- **Armed flag**
  - Set by the first Tick after leaving IDLE or DONE.
  - Cleared on entering ACCEL.
  - A counter already sitting at Target when Go arrives does not cause an immediate stop.
- **DECEL**
  - On a Tick with dwell==DWELL_TICKS-1: if Speed<11, Speed increments by 1 and dwell clears.
  - If Speed is already 11, the state moves to DONE and RunEn drops to 0.
  - Halt and Target match are ignored in DECEL.
- **DONE**
  - Done=1, Speed=11, RunEn=0.
  - Go → ACCEL (restart). Halt → IDLE.
- **Go/Halt conflicts**
  - Go and Halt in the same cycle: Halt wins.
  - Go while Busy is ignored.
  - Halt in IDLE is ignored.
- **Speed saturation**: never decrements below 00 and never increments above 11.
- **Tick outside ACCEL/DECEL**: has no effect on dwell.

## Timing
- **Reset values** (asynchronous, in effect immediately): State=IDLE, Speed=2'b11, RunEn=0, Busy=0, Done=0, StateOut=0, dwell=0, armed=0.
- **Go latency**: Go sampled at edge n → ACCEL, RunEn=1 and Busy=1 visible after edge n. This is 1 cycle without the macro and 3 cycles with it.
- **Speed step**: the Tick that completes a dwell produces the new Speed value after that same edge.
- **Target match**: the match cycle produces DECEL after the next edge. RunEn stays 1 through DECEL, so the counter may pass Target during the ramp-down.
- **Ramp length**: a full ramp (11→00) takes exactly 3·DWELL_TICKS Ticks.
- **Reset mid-run**: aborts immediately and all values return to their reset values.

## Configuration
- Macro: SPEED_SEQ_BTN_SYNC_EN.
- **Defined**: Go and Halt each pass through a 2-flop synchronizer followed by a rising-edge detector, so raw asynchronous button levels are accepted. Each press is exactly one command, and adds 2 cycles of latency.
- **Undefined**: Go and Halt are treated as synchronous single-cycle pulses and used directly. A level held high re-issues the command every cycle; this only matters in DONE/IDLE.

## Structure
- Package speed_seq_pkg holds:
  - state_t enum (3-bit, encodings above);
  - speed constants SPD_FAST=2'b00 and SPD_SLOW=2'b11.
- One sub-module, btn_pulse_sync (synchronizer plus edge detect). It is instantiated twice, only under SPEED_SEQ_BTN_SYNC_EN.
- The FSM, dwell counter and armed flag live in speed_sequencer.

## Test plan
All scenarios use DWELL_TICKS=2 and the macro undefined unless noted.
- Reset check: assert Reset mid-CRUISE → Speed=11, RunEn=0, Busy=0, StateOut=0 with no clock edge.
- Full ramp: Go, Target=15, a Tick every 4 cycles → Speed sequence 11,10,01,00 after Ticks 2, 4 and 6. CRUISE is entered on Tick 6.
- Target stop: CounterValue reaches 9 with Target=9 in CRUISE → DECEL the next cycle. Speed sequence 00→01→10→11 every 2 Ticks, then DONE after 8 Ticks, with RunEn=0 and Done=1.
- Halt during ACCEL at Speed=10 → DECEL at 10. DONE follows after 4 Ticks. Simultaneous Go+Halt in DONE → IDLE.
- Armed check: CounterValue=Target=0 at Go → no DECEL until after the first Tick. Go while Busy → no state change.
- Macro defined: Go held high for 10 cycles → exactly one ACCEL entry, 3 cycles after the rise.
